// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the write-back stage of the single-cycle RISC-V core.
// Holds the major opcodes, the load funct3 encodings and the write-back FSM
// states.
package writeback_unit_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_ILOAD  = 7'b0000011;
  localparam logic [6:0] OP_STYPE  = 7'b0100011;
  localparam logic [6:0] OP_BTYPE  = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // Load funct3 (instruction[14:12])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WAIT_IO  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// load_extend: combinational byte/half/word select with sign or zero
// extension for loads.
// Ports:
//   funct3      load width/signedness
//   offset      byte offset within the word (address bits [1:0])
//   word        aligned data-memory read word
//   data        extended load value
//   misaligned  half access at an odd offset or word access at offset != 0
//   bad_funct3  funct3 is not a defined load encoding
module load_extend
  import writeback_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            bad_funct3
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = offset[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = |offset;
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: register-file write side of the single-cycle core.
// Selects and formats the write-back value from ALU/immediate/PC/memory/IO
// sources and owns the stall handshake for loads and ecall input.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_in        instruction issued this cycle
//   instruction     issued instruction (opcode, rd, funct3 used)
//   pc, imm         PC and decoded immediate of the issued instruction
//   alu_result      ALU output, also the load byte address
//   mem_rdata/mem_rvalid  data-memory read word and its one-cycle valid
//   io_data/io_valid      ecall input value and its valid
//   WriteData/Write/WriteReg  register-file write port (Write is a pulse)
//   stall           hold fetch/issue while a load or ecall is outstanding
//   wb_err          one-cycle pulse on misaligned/bad load or memory timeout
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] io_data,
  input  logic            io_valid,
  output logic [XLEN-1:0] WriteData,
  output logic            Write,
  output logic [4:0]      WriteReg,
  output logic            stall,
  output logic            wb_err
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  wb_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [4:0]      rd_q, rd_n;
  logic [2:0]      f3_q, f3_n;
  logic [1:0]      off_q, off_n;
  logic [XLEN-1:0] wdata_n;
  logic [4:0]      wreg_n;
  logic            write_n, err_n;

  logic            do_commit;
  logic [XLEN-1:0] commit_val;
  logic [4:0]      commit_rd;

  logic [6:0]      opcode;
  logic [4:0]      rd_in;
  logic [2:0]      f3_in;
  logic            unused_instr;

  logic [2:0]      ext_f3;
  logic [1:0]      ext_off;
  logic [XLEN-1:0] ext_data;
  logic            ext_misaligned, ext_bad;

  assign opcode       = instruction[6:0];
  assign rd_in        = instruction[11:7];
  assign f3_in        = instruction[14:12];
  assign unused_instr = ^instruction[31:15];

  // One extender serves both paths: in IDLE it sees the issuing load (for
  // the misalignment check), otherwise the latched load being completed.
  assign ext_f3  = (state == WB_IDLE) ? f3_in : f3_q;
  assign ext_off = (state == WB_IDLE) ? alu_result[1:0] : off_q;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3     (ext_f3),
    .offset     (ext_off),
    .word       (mem_rdata),
    .data       (ext_data),
    .misaligned (ext_misaligned),
    .bad_funct3 (ext_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WB_IDLE;
      cnt       <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      WriteData <= '0;
      Write     <= 1'b0;
      WriteReg  <= '0;
      wb_err    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rd_q      <= rd_n;
      f3_q      <= f3_n;
      off_q     <= off_n;
      WriteData <= wdata_n;
      Write     <= write_n;
      WriteReg  <= wreg_n;
      wb_err    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rd_n       = rd_q;
    f3_n       = f3_q;
    off_n      = off_q;
    err_n      = 1'b0;
    do_commit  = 1'b0;
    commit_val = '0;
    commit_rd  = rd_q;
    stall      = (state != WB_IDLE);

    case (state)
      WB_IDLE: begin
        if (valid_in) begin
          commit_rd = rd_in;
          case (opcode)
            OP_RTYPE, OP_IARITH: begin
              do_commit  = 1'b1;
              commit_val = alu_result;
            end
            OP_LUI: begin
              do_commit  = 1'b1;
              commit_val = imm;
            end
            OP_AUIPC: begin
              do_commit  = 1'b1;
              commit_val = pc + imm;
            end
            OP_JAL, OP_JALR: begin
              do_commit  = 1'b1;
              commit_val = pc + XLEN'(4);
            end
            OP_ILOAD: begin
              if (ext_misaligned) begin
                err_n = 1'b1;
              end else begin
                state_n = WB_WAIT_MEM;
                cnt_n   = '0;
                rd_n    = rd_in;
                f3_n    = f3_in;
                off_n   = alu_result[1:0];
                stall   = 1'b1;
              end
            end
            OP_ECALL: begin
              state_n = WB_WAIT_IO;
              rd_n    = rd_in;
              stall   = 1'b1;
            end
            default: ;
          endcase
        end
      end

      WB_WAIT_MEM: begin
        // mem_rvalid is tested before the limit so it wins on the last cycle
        if (mem_rvalid) begin
          state_n = WB_IDLE;
          if (ext_bad) begin
            err_n = 1'b1;
          end else begin
            do_commit  = 1'b1;
            commit_val = ext_data;
          end
        end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
          state_n = WB_IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      WB_WAIT_IO: begin
        if (io_valid) begin
          state_n    = WB_IDLE;
          do_commit  = 1'b1;
          commit_val = io_data;
        end
      end

      default: state_n = WB_IDLE;
    endcase

    // x0 writes are suppressed; the write port holds its last value otherwise
    write_n = do_commit && (commit_rd != 5'd0);
    wdata_n = write_n ? commit_val : WriteData;
    wreg_n  = write_n ? commit_rd  : WriteReg;
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] IARITH = 7'b0010011;
  localparam logic [6:0] ILOAD  = 7'b0000011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] ECALL  = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, valid_in, mem_rvalid, io_valid;
  logic [31:0] instruction, pc, imm, alu_result, mem_rdata, io_data;
  logic [31:0] WriteData;
  logic        Write, stall, wb_err;
  logic [4:0]  WriteReg;

  int passed = 0;
  int total  = 0;
  logic [31:0] last_wdata = '0;
  logic [4:0]  last_wreg  = '0;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instruction(instruction),
    .pc(pc), .imm(imm), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .io_data(io_data), .io_valid(io_valid),
    .WriteData(WriteData), .Write(Write), .WriteReg(WriteReg),
    .stall(stall), .wb_err(wb_err)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'b0, f3, rd, op};
  endfunction

  // Load result from the ISA rules: shift the word down, mask, sign-adjust.
  function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      2: return w;
      4: return b;
      5: return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_misaligned(input int f3, input int off);
    int size;
    size = (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 1;
    return (off % size) != 0;
  endfunction

  function automatic bit ref_bad(input int f3);
    return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; instruction = mk(RTYPE, 5'd5, 3'd0);
    alu_result = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (Write !== 1'b0) $display("FAIL reset_write got=%b exp=0", Write); else passed++;
      total++; if (WriteData !== 32'd0) $display("FAIL reset_wdata got=%h exp=0", WriteData); else passed++;
      total++; if (WriteReg !== 5'd0) $display("FAIL reset_wreg got=%0d exp=0", WriteReg); else passed++;
      total++; if (wb_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", wb_err); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else passed++;
    end
    rst = 1'b0; valid_in = 1'b0;
  endtask

  task automatic run_single(input logic [6:0] op, input logic [4:0] rd,
                            input logic [31:0] p, input logic [31:0] i, input logic [31:0] a);
    logic [31:0] exp;
    if (op == LUI) exp = i;
    else if (op == AUIPC) exp = p + i;
    else if (op == JAL || op == JALR) exp = p + 32'd4;
    else exp = a;
    step();
    instruction = mk(op, rd, 3'($urandom)); pc = p; imm = i; alu_result = a; valid_in = 1'b1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL single_stall op=%h got=%b exp=0", op, stall); else passed++;
    total++; if (Write !== 1'b0) $display("FAIL single_pre_write op=%h got=%b exp=0", op, Write); else passed++;
    step();
    valid_in = 1'b0; pc = $urandom; imm = $urandom; alu_result = $urandom;
    total++; if (Write !== (rd != 5'd0)) $display("FAIL single_write op=%h rd=%0d got=%b exp=%b", op, rd, Write, rd != 5'd0); else passed++;
    total++; if (wb_err !== 1'b0) $display("FAIL single_err op=%h got=%b exp=0", op, wb_err); else passed++;
    if (rd != 5'd0) begin
      total++; if (WriteData !== exp) $display("FAIL single_wdata op=%h got=%h exp=%h", op, WriteData, exp); else passed++;
      total++; if (WriteReg !== rd) $display("FAIL single_wreg op=%h got=%0d exp=%0d", op, WriteReg, rd); else passed++;
      last_wdata = exp; last_wreg = rd;
    end
  endtask

  task automatic test_single_cycle();
    logic [6:0] ops [6] = '{RTYPE, IARITH, LUI, AUIPC, JAL, JALR};
    run_single(RTYPE, 5'd5, 32'h0, 32'h0, 32'h0000_1234);
    run_single(RTYPE, 5'd0, 32'h0, 32'h0, 32'h0000_1234);
    run_single(JAL, 5'd1, 32'h100, 32'h0, 32'h0);
    run_single(AUIPC, 5'd2, 32'h100, 32'h2000, 32'h0);
    run_single(JALR, 5'd3, 32'hFFFF_FFFC, 32'h0, 32'h0);
    for (int n = 0; n < 20; n++)
      run_single(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
  endtask

  task automatic run_load(input int f3, input int off, input logic [31:0] word,
                          input logic [4:0] rd, input int delay);
    bit mis, bad;
    int stalls, spurious;
    logic [31:0] exp;
    mis = ref_misaligned(f3, off); bad = ref_bad(f3); exp = ref_load(f3, off, word);
    step();
    instruction = mk(ILOAD, rd, 3'(f3));
    alu_result = {30'($urandom), 2'(off)}; valid_in = 1'b1;
    #1;
    total++; if (stall !== !mis) $display("FAIL load_issue_stall f3=%0d off=%0d got=%b exp=%b", f3, off, stall, !mis); else passed++;
    step();
    valid_in = 1'b0; alu_result = $urandom;
    if (mis) begin
      total++; if (wb_err !== 1'b1) $display("FAIL misalign_err f3=%0d off=%0d got=%b exp=1", f3, off, wb_err); else passed++;
      total++; if (Write !== 1'b0) $display("FAIL misalign_write got=%b exp=0", Write); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL misalign_stall got=%b exp=0", stall); else passed++;
      return;
    end
    stalls = 1; spurious = 0;
    for (int d = 1; d <= delay; d++) begin
      mem_rvalid = (d == delay);
      mem_rdata  = (d == delay) ? word : $urandom;
      #1;
      if (stall === 1'b1) stalls++;
      if (Write !== 1'b0 || wb_err !== 1'b0) spurious++;
      step();
    end
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    total++; if (stalls != 1 + delay) $display("FAIL load_stall_cycles got=%0d exp=%0d", stalls, 1 + delay); else passed++;
    total++; if (spurious != 0) $display("FAIL load_early_output got=%0d exp=0", spurious); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL load_stall_drop got=%b exp=0", stall); else passed++;
    total++; if (wb_err !== bad) $display("FAIL load_err f3=%0d got=%b exp=%b", f3, wb_err, bad); else passed++;
    total++; if (Write !== (!bad && rd != 5'd0)) $display("FAIL load_write f3=%0d got=%b exp=%b", f3, Write, !bad && rd != 5'd0); else passed++;
    if (!bad && rd != 5'd0) begin
      total++; if (WriteData !== exp) $display("FAIL load_wdata f3=%0d off=%0d got=%h exp=%h", f3, off, WriteData, exp); else passed++;
      total++; if (WriteReg !== rd) $display("FAIL load_wreg got=%0d exp=%0d", WriteReg, rd); else passed++;
      last_wdata = exp; last_wreg = rd;
    end
  endtask

  task automatic test_loads();
    int f3s [5] = '{0, 1, 2, 4, 5};
    run_load(0, 3, 32'h80FF_0000, 5'd6, 3);
    run_load(4, 3, 32'h80FF_0000, 5'd6, 3);
    run_load(5, 2, 32'h80FF_0000, 5'd6, 3);
    run_load(2, 2, 32'h1234_5678, 5'd6, 3);
    run_load(3, 0, 32'h1234_5678, 5'd6, 2);
    for (int n = 0; n < 16; n++)
      run_load(f3s[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom,
               5'($urandom_range(0, 31)), $urandom_range(1, 12));
  endtask

  task automatic test_timeout();
    int stalls;
    step();
    instruction = mk(ILOAD, 5'd7, 3'd2); alu_result = 32'h40; valid_in = 1'b1;
    step();
    valid_in = 1'b0; stalls = 0;
    for (int d = 1; d <= 16; d++) begin
      #1;
      if (stall === 1'b1) stalls++;
      step();
    end
    total++; if (stalls != 16) $display("FAIL timeout_stall_cycles got=%0d exp=16", stalls); else passed++;
    total++; if (wb_err !== 1'b1) $display("FAIL timeout_err got=%b exp=1", wb_err); else passed++;
    total++; if (Write !== 1'b0) $display("FAIL timeout_write got=%b exp=0", Write); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL timeout_stall got=%b exp=0", stall); else passed++;
    step();
    total++; if (wb_err !== 1'b0) $display("FAIL timeout_err_pulse got=%b exp=0", wb_err); else passed++;
    run_load(2, 0, 32'hCAFE_F00D, 5'd8, 16);
  endtask

  task automatic run_ecall(input logic [4:0] rd, input logic [31:0] data, input int delay);
    int stalls;
    step();
    instruction = mk(ECALL, rd, 3'd0); valid_in = 1'b1;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL ecall_issue_stall got=%b exp=1", stall); else passed++;
    step();
    valid_in = 1'b0; stalls = 1;
    for (int d = 1; d <= delay; d++) begin
      io_valid = (d == delay);
      io_data  = (d == delay) ? data : $urandom;
      #1;
      if (stall === 1'b1) stalls++;
      step();
    end
    io_valid = 1'b0;
    total++; if (stalls != 1 + delay) $display("FAIL ecall_stall_cycles got=%0d exp=%0d", stalls, 1 + delay); else passed++;
    total++; if (Write !== 1'b1) $display("FAIL ecall_write got=%b exp=1", Write); else passed++;
    total++; if (WriteData !== data) $display("FAIL ecall_wdata got=%h exp=%h", WriteData, data); else passed++;
    total++; if (WriteReg !== rd) $display("FAIL ecall_wreg got=%0d exp=%0d", WriteReg, rd); else passed++;
    last_wdata = data; last_wreg = rd;
  endtask

  task automatic test_ecall();
    run_ecall(5'd9, 32'h2A, 9);
    for (int n = 0; n < 3; n++)
      run_ecall(5'($urandom_range(1, 31)), $urandom, $urandom_range(1, 20));
  endtask

  task automatic test_no_write();
    logic [6:0] ops [2] = '{STYPE, BTYPE};
    for (int n = 0; n < 2; n++) begin
      step();
      instruction = mk(ops[n], 5'd12, 3'd2); alu_result = $urandom; valid_in = 1'b1;
      #1;
      total++; if (stall !== 1'b0) $display("FAIL nowrite_stall got=%b exp=0", stall); else passed++;
      step();
      valid_in = 1'b0;
      total++; if (Write !== 1'b0) $display("FAIL nowrite_write got=%b exp=0", Write); else passed++;
      total++; if (WriteData !== last_wdata) $display("FAIL nowrite_hold got=%h exp=%h", WriteData, last_wdata); else passed++;
      total++; if (WriteReg !== last_wreg) $display("FAIL nowrite_hold_reg got=%0d exp=%0d", WriteReg, last_wreg); else passed++;
    end
    step();
    mem_rvalid = 1'b1; io_valid = 1'b1; io_data = $urandom; mem_rdata = $urandom;
    step();
    mem_rvalid = 1'b0; io_valid = 1'b0;
    total++; if (Write !== 1'b0 || wb_err !== 1'b0) $display("FAIL idle_ignore got=%b%b exp=00", Write, wb_err); else passed++;
  endtask

  task automatic test_reset_mid();
    step();
    instruction = mk(ILOAD, 5'd4, 3'd2); alu_result = 32'h80; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (stall !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", stall); else passed++;
    total++; if (WriteData !== 32'd0) $display("FAIL rstmid_wdata got=%h exp=0", WriteData); else passed++;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    total++; if (Write !== 1'b0) $display("FAIL rstmid_write got=%b exp=0", Write); else passed++;
    total++; if (wb_err !== 1'b0) $display("FAIL rstmid_err got=%b exp=0", wb_err); else passed++;
    last_wdata = '0; last_wreg = '0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; mem_rvalid = 1'b0; io_valid = 1'b0;
    instruction = '0; pc = '0; imm = '0; alu_result = '0; mem_rdata = '0; io_data = '0;
    test_reset();
    test_single_cycle();
    test_loads();
    test_timeout();
    test_ecall();
    test_no_write();
    test_reset_mid();
    run_single(RTYPE, 5'd5, 32'h0, 32'h0, 32'h0000_1234);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
